// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the
// iterative radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Magnitude select of one Booth digit.
  localparam logic [1:0] MAG_0 = 2'd0;
  localparam logic [1:0] MAG_1 = 2'd1;
  localparam logic [1:0] MAG_2 = 2'd2;

  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } digit_t;

  function automatic int booth_digits(input int w);
    return w / 2 + 1;
  endfunction

  // Radix-4 recoding of a 3-bit overlapping window.
  // 3'b111 is a zero digit, not a negative one.
  function automatic digit_t booth_enc(input logic [2:0] win);
    digit_t d;
    d = '{neg: 1'b0, mag: MAG_0};
    unique case (win)
      3'b000, 3'b111: d = '{neg: 1'b0, mag: MAG_0};
      3'b001, 3'b010: d = '{neg: 1'b0, mag: MAG_1};
      3'b011:         d = '{neg: 1'b0, mag: MAG_2};
      3'b100:         d = '{neg: 1'b1, mag: MAG_2};
      3'b101, 3'b110: d = '{neg: 1'b1, mag: MAG_1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth partial product
// as a one's-complement word plus a carry-in bit.
import booth_pkg::*;

module booth_pp_gen #(
  parameter int W = 7
) (
  input  logic [W:0]   a_ext,
  input  logic [2:0]   win,
  output logic [W+1:0] gen,
  output logic         neg
);

  digit_t       d;
  logic [W+1:0] mag;

  // Select 0, A or 2A, invert for negative digits.
  always_comb begin
    d   = booth_enc(win);
    mag = '0;
    unique case (d.mag)
      MAG_1:   mag = {a_ext[W], a_ext};
      MAG_2:   mag = {a_ext, 1'b0};
      default: mag = '0;
    endcase
    gen = d.neg ? ~mag : mag;
    neg = d.neg;
  end

endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier,
// one digit per clock, valid/ready on both sides.
import booth_pkg::*;

module booth_seq_mul #(
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int D  = booth_digits(W);
  localparam int CW = $clog2(D + 1);
  localparam int SW = 2 * D + 1;
  localparam int AW = 2 * W + 2;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [W:0]      a_ext;
  logic [SW-1:0]   sr;

  logic [W:0]      a_x;
  logic [2*D-1:0]  b_x;
  logic [W+1:0]    gen;
  logic            neg;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   acc_nx;
  logic            accept;

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign a_x = {mode & a[W-1], a};
  assign b_x = {{(2*D-W){mode & b[W-1]}}, b};

  booth_pp_gen #(.W(W)) u_pp (
    .a_ext (a_ext),
    .win   (sr[2:0]),
    .gen   (gen),
    .neg   (neg)
  );

  // Weight the current partial product by 4^cnt.
  always_comb begin
    addend = ({{W{gen[W+1]}}, gen} + AW'(neg))
             << (2 * cnt);
    acc_nx = acc + addend;
  end

  // FSM, operand latch, digit loop and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_ext     <= '0;
      sr        <= '0;
      out_valid <= 1'b0;
      p         <= '0;
    end else if (accept) begin
      state     <= BUSY;
      a_ext     <= a_x;
      sr        <= {b_x, 1'b0};
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        BUSY: begin
          acc <= acc_nx;
          sr  <= SW'($signed(sr) >>> 2);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(D - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            p         <= acc_nx[2*W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: directed vectors on W=7 plus
// randomised scoreboard sweeps at W=2,7,12,16.
module tb_booth_seq_mul;

  localparam int W    = 7;
  localparam int NOPS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;

  int checks = 0;
  int errors = 0;
  int sweep_cnt = 0;

  booth_seq_mul #(.W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic         m;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic run_op(input logic m,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        output logic [2*W-1:0] pr,
                        output int lat,
                        output int busy_bad);
    @(negedge clk);
    mode      = m;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    mode     = ~m;
    lat      = -1;
    busy_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) busy_bad++;
    end
    pr = p;
  endtask

  initial begin
    logic [2*W-1:0] pr;
    int lat;
    int bb;
    int seen;

    vecs[0] = '{1'b0, 7'd127,  7'd127, 14'h3F01};
    vecs[1] = '{1'b0, 7'd85,   7'd127, 14'h2A2B};
    vecs[2] = '{1'b0, 7'd0,    7'd99,  14'h0000};
    vecs[3] = '{1'b1, 7'h40,   7'h40,  14'h1000};
    vecs[4] = '{1'b1, 7'h40,   7'd63,  14'h3040};
    vecs[5] = '{1'b1, 7'h7F,   7'h7F,  14'h0001};
    vecs[6] = '{1'b1, 7'h7F,   7'd63,  14'h3FC1};
    vecs[7] = '{1'b0, 7'd127,  7'd1,   14'h007F};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_p", 32'(p), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    chk("idle_stays_idle", 32'(seen), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].av, vecs[i].bv,
             pr, lat, bb);
      chk($sformatf("vec%0d_p", i), 32'(pr),
          32'(vecs[i].exp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_busy_rdy", i), 32'(bb),
          32'd0);
    end

    // Back-pressure then same-edge retire and accept.
    @(negedge clk);
    mode      = 1'b0;
    a         = 7'd100;
    b         = 7'd3;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("bp_lat", 32'(lat), 32'd5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k),
          {16'd0, out_valid, in_ready, p},
          {16'd0, 1'b1, 1'b0, 14'd300});
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 7'd9;
    b         = 7'd11;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lat", 32'(lat), 32'd5);
    chk("b2b_p", 32'(p), 32'd99);

    // Reset during BUSY abandons the operation.
    @(negedge clk);
    mode     = 1'b0;
    a        = 7'd127;
    b        = 7'd127;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_p", 32'(p), 32'd0);
    chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_busy_no_result", 32'(seen), 32'd0);
    run_op(1'b0, 7'd3, 7'd5, pr, lat, bb);
    chk("after_rst_p", 32'(pr), 32'd15);
    chk("after_rst_lat", 32'(lat), 32'd5);

    for (int c = 0; c < 60000 && sweep_cnt < 4; c++)
      @(posedge clk);
    chk("sweeps_done", 32'(sweep_cnt), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int WW = (g == 0) ? 2 :
                        (g == 1) ? 7 :
                        (g == 2) ? 12 : 16;

    logic            s_rst;
    logic            s_iv;
    logic            s_ir;
    logic [WW-1:0]   s_a;
    logic [WW-1:0]   s_b;
    logic            s_m;
    logic            s_ov;
    logic            s_or;
    logic [2*WW-1:0] s_p;

    booth_seq_mul #(.W(WW)) u (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .a         (s_a),
      .b         (s_b),
      .mode      (s_m),
      .out_valid (s_ov),
      .out_ready (s_or),
      .p         (s_p)
    );

    initial begin
      logic [2*WW-1:0] q[$];
      logic [2*WW-1:0] expv;
      logic [WW-1:0]   amin;
      longint sa;
      longint sb;
      longint pr;
      int issued;
      int got;
      bit acc_f;

      issued = 0;
      got    = 0;
      acc_f  = 1'b0;
      amin   = {1'b1, {(WW-1){1'b0}}};
      s_rst  = 1'b1;
      s_iv   = 1'b0;
      s_or   = 1'b0;
      s_a    = '0;
      s_b    = '0;
      s_m    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      s_rst = 1'b0;

      for (int cyc = 0; cyc < 20000 && got < NOPS; cyc++) begin
        @(negedge clk);
        if (acc_f) s_iv = 1'b0;
        acc_f = 1'b0;
        s_or  = ($urandom_range(0, 3) != 0);
        if (!s_iv && issued < NOPS) begin
          s_iv = 1'b1;
          case (issued)
            0: begin s_a = '1; s_b = '1; s_m = 1'b0; end
            1: begin s_a = amin; s_b = amin; s_m = 1'b1; end
            2: begin s_a = amin; s_b = '1; s_m = 1'b1; end
            3: begin s_a = '1; s_b = amin; s_m = 1'b0; end
            default: begin
              s_a = WW'($urandom);
              s_b = WW'($urandom);
              s_m = 1'($urandom);
            end
          endcase
        end
        #1;
        if (s_ov && s_or) begin
          if (q.size() == 0) begin
            chk($sformatf("sw%0d_order", WW), 32'd1, 32'd0);
          end else begin
            expv = q.pop_front();
            chk($sformatf("sw%0d_p%0d", WW, got),
                32'(s_p), 32'(expv));
          end
          got++;
        end
        if (s_iv && s_ir) begin
          sa = s_m ? longint'($signed(s_a)) : longint'(s_a);
          sb = s_m ? longint'($signed(s_b)) : longint'(s_b);
          pr = sa * sb;
          expv = pr[2*WW-1:0];
          q.push_back(expv);
          issued++;
          acc_f = 1'b1;
        end
      end
      chk($sformatf("sw%0d_count", WW), 32'(got), NOPS);
      chk($sformatf("sw%0d_left", WW), 32'(q.size()), 32'd0);
      sweep_cnt++;
    end
  end

endmodule

// File: doc/booth_seq_mul.md
# booth_seq_mul

Parametrised iterative radix-4 Booth multiplier for the FMAU mantissa path: multiplies two W-bit operands, unsigned or two's-complement selected per operation, and retires one Booth digit per clock. It reuses the one's-complement-plus-carry partial-product form (`gen` word plus `neg` bit) used by the combinational Booth arrays. A sequential accumulator replaces the compressor tree, giving an area-cheap multiplier for the narrow-posit configurations. A valid/ready handshake on both sides lets the block sit between the decode and normalise stages.

## Interface
- `W`, default 7: operand width, legal range 2..32.
- `D`, default W/2+1 (floor division, derived, not overridable): number of Booth digits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand offer.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  multiplicand.
- `b`  in  W  multiplier.
- `mode`  in  1  0 = unsigned, 1 = two's complement; applies to both operands.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts the product.
- `p`  out  2W  product: unsigned or two's complement, matching the latched mode.

## Operation
- States: IDLE, BUSY, DONE. The state register, digit counter `cnt` (width clog2(D+1)) and accumulator are registered.
- Accept: `in_valid && in_ready` on a rising edge.
  - Latch `a`, extended to W+1 bits: zero-extended if mode=0, sign-extended if mode=1.
  - Latch `b`, extended the same way to 2D bits, with a 0 appended below the LSB. This gives a (2D+1)-bit shift register `sr`.
  - Latch `mode`. Clear `acc` and `cnt`. Go to BUSY.
- BUSY, every cycle:
  - Booth-encode `sr[2:0]` to a digit in {-2,-1,0,+1,+2}.
  - Sub-module output: `gen` (W+2 bits) holds the magnitude multiple (0, A or 2A), bitwise inverted when the digit is negative. `neg` = 1 for a negative digit with nonzero magnitude.
  - Update: acc += (sign_extend(gen) << 2·cnt) + (neg << 2·cnt), using a 2W+2-bit accumulator.
  - Then `sr >>= 2` (arithmetic) and `cnt++`.
  - After the BUSY cycle with cnt = D-1, go to DONE.
- DONE:
  - `out_valid` = 1 and `p = acc[2W-1:0]`. Both hold stable until `out_valid && out_ready`.
  - On that handshake, go to IDLE, or straight to BUSY if a new operand is accepted in the same edge.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. This is combinational from `out_ready`, the only combinational in-to-out path.
- Arithmetic: all additions are modulo 2^(2W+2). Truncation to 2W bits is exact for both modes at every legal W.

## Timing
- Reset: after the first rising edge with `rst` high, state = IDLE, `out_valid` = 0, `p` = 0, `cnt` = 0, `acc` = 0. Inputs are ignored while `rst` is high.
- Reset asserted in BUSY or DONE abandons the operation. No `out_valid` is produced for it.
- Latency: accept in cycle 0; BUSY in cycles 1..D; `out_valid` high from cycle D+1. For W=7, D=4, so `out_valid` rises in cycle 5.
- Throughput: one result per D+1 cycles with `out_ready` held high (back-to-back accept in the DONE cycle).
- Back-pressure: DONE holds indefinitely. `in_ready` is 0 while `out_ready` is 0.
- `in_valid` deasserted in IDLE: no state change. `mode`, `a` and `b` are only sampled on accept.

## Structure
- Package `booth_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - localparam function `booth_digits(W)` returning W/2+1;
  - Booth digit encoding constants.
- Sub-module `booth_pp_gen` (combinational):
  - ports: `a_ext` [W:0], `win` [2:0], output `gen` [W+1:0], output `neg`;
  - parameter W;
  - it is the single-digit generaliser of the fixed-width `gen`/`sign` partial-product generator.
- Top `booth_seq_mul` contains the FSM, counter, shift register and accumulator.

## Test plan
- W=7, mode=0, a=127, b=127, `out_ready`=1 → `out_valid` in cycle 5, `p`=0x3F01; `in_ready`=0 in cycles 1–4.
- W=7, mode=0, a=85, b=127 → `p`=0x2A2B. Then a=0, b=99 → `p`=0x0000.
- W=7, mode=1, a=-64 (0x40), b=-64 → `p`=0x1000. Then a=-64, b=63 → `p`=0x3040 (i.e. -4032).
- Hold `out_ready`=0 for 10 cycles after `out_valid` rises → `p` stable, `out_valid` stays 1, `in_ready`=0. Release with `in_valid` high → product retired and new operands accepted in the same edge; the next `out_valid` comes D+1 cycles later.
- Assert `rst` for 1 cycle in BUSY (cycle 2) → next cycle state = IDLE, `out_valid`=0, `p`=0. The following operation 3×5 (mode=0) gives `p`=15.
- Random sweep, W ∈ {2,7,12,16}, both modes, random `out_ready` stalls → `p` equals the reference product modulo 2^(2W). The scoreboard checks order and count.
